// File: rtl/axi_mem_reg_slice.sv
// Purpose : full AXI4 register slice (AW, W, B, AR, R) ahead of the DDR address remapper.
// Latency : one cycle per channel; sustains one beat per cycle with the sink always ready.
// Backpr. : 2-entry skid per channel; input ready is a flop that drops one beat after the sink stalls.
// Ports   : s_axi_* faces the SoC master, m_axi_* faces the remapper; aclk / aresetn (async, active-low).

// One skid-buffer channel. OUT drives the sink, SK catches the beat already
// in flight when the sink stalls. in_rdy is the registered !SK.valid.
module axi_mem_reg_slice_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    logic         out_v_q, out_v_d;
    logic         sk_v_q,  sk_v_d;
    logic         rdy_q,   rdy_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic [W-1:0] sk_dat_q,  sk_dat_d;
    logic         in_fire, out_fire;

    assign in_fire  = in_vld & rdy_q;
    assign out_fire = out_v_q & out_rdy;

    always_comb begin
        out_v_d   = out_v_q;
        sk_v_d    = sk_v_q;
        out_dat_d = out_dat_q;
        sk_dat_d  = sk_dat_q;
        if (!out_v_q) begin
            // EMPTY
            if (in_fire) begin
                out_v_d   = 1'b1;
                out_dat_d = in_dat;
            end
        end else if (!sk_v_q) begin
            // HALF
            if (in_fire && out_fire) begin
                out_dat_d = in_dat;
            end else if (in_fire) begin
                sk_v_d   = 1'b1;
                sk_dat_d = in_dat;
            end else if (out_fire) begin
                out_v_d = 1'b0;
            end
        end else begin
            // FULL: rdy_q is low, so only the drain side can move
            if (out_fire) begin
                out_dat_d = sk_dat_q;
                sk_v_d    = 1'b0;
            end
        end
        rdy_d = ~sk_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            sk_v_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            out_v_q <= out_v_d;
            sk_v_q  <= sk_v_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload is don't-care while its valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        out_dat_q <= out_dat_d;
        sk_dat_q  <= sk_dat_d;
    end

    assign in_rdy  = rdy_q;
    assign out_vld = out_v_q;
    assign out_dat = out_dat_q;
endmodule

module axi_mem_reg_slice #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // slave side (from master)
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // master side (to remapper)
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int A_W = ADDR_WIDTH + ID_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4;
    localparam int W_W = DATA_WIDTH + DATA_WIDTH/8 + 1;
    localparam int B_W = ID_WIDTH + 2;
    localparam int R_W = DATA_WIDTH + ID_WIDTH + 2 + 1;

    logic [A_W-1:0] aw_in_dat, aw_out_dat, ar_in_dat, ar_out_dat;
    logic [W_W-1:0] w_in_dat,  w_out_dat;
    logic [B_W-1:0] b_in_dat,  b_out_dat;
    logic [R_W-1:0] r_in_dat,  r_out_dat;

    assign aw_in_dat = {s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                        s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};
    assign {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_out_dat;
    assign ar_in_dat = {s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
    assign {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_out_dat;
    assign w_in_dat = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out_dat;
    assign b_in_dat = {m_axi_bid, m_axi_bresp};
    assign {s_axi_bid, s_axi_bresp} = b_out_dat;
    assign r_in_dat = {m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast};
    assign {s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast} = r_out_dat;

    axi_mem_reg_slice_chan #(.W(A_W)) u_aw (
        .clk(aclk), .rst_n(aresetn),
        .in_vld(s_axi_awvalid), .in_rdy(s_axi_awready), .in_dat(aw_in_dat),
        .out_vld(m_axi_awvalid), .out_rdy(m_axi_awready), .out_dat(aw_out_dat));

    axi_mem_reg_slice_chan #(.W(W_W)) u_w (
        .clk(aclk), .rst_n(aresetn),
        .in_vld(s_axi_wvalid), .in_rdy(s_axi_wready), .in_dat(w_in_dat),
        .out_vld(m_axi_wvalid), .out_rdy(m_axi_wready), .out_dat(w_out_dat));

    axi_mem_reg_slice_chan #(.W(A_W)) u_ar (
        .clk(aclk), .rst_n(aresetn),
        .in_vld(s_axi_arvalid), .in_rdy(s_axi_arready), .in_dat(ar_in_dat),
        .out_vld(m_axi_arvalid), .out_rdy(m_axi_arready), .out_dat(ar_out_dat));

    axi_mem_reg_slice_chan #(.W(B_W)) u_b (
        .clk(aclk), .rst_n(aresetn),
        .in_vld(m_axi_bvalid), .in_rdy(m_axi_bready), .in_dat(b_in_dat),
        .out_vld(s_axi_bvalid), .out_rdy(s_axi_bready), .out_dat(b_out_dat));

    axi_mem_reg_slice_chan #(.W(R_W)) u_r (
        .clk(aclk), .rst_n(aresetn),
        .in_vld(m_axi_rvalid), .in_rdy(m_axi_rready), .in_dat(r_in_dat),
        .out_vld(s_axi_rvalid), .out_rdy(s_axi_rready), .out_dat(r_out_dat));
endmodule

// File: tb/tb_axi_mem_reg_slice.sv
// Purpose : directed self-checking bench for axi_mem_reg_slice.
// Latency : inputs driven 1ns after aclk rise, outputs sampled at the same point.
// Backpr. : sink readies driven directly per scenario (stalls, random ready).
module tb_axi_mem_reg_slice;
    logic        aclk, aresetn;
    logic [35:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
    logic [7:0]  s_axi_awid, s_axi_awlen, s_axi_arid, s_axi_arlen;
    logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
    logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
    logic [1:0]  s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
    logic        s_axi_awlock, s_axi_arlock, m_axi_awlock, m_axi_arlock;
    logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_arcache, s_axi_arqos;
    logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_arcache, m_axi_arqos;
    logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
    logic [7:0]  s_axi_wstrb, m_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
    logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int errors = 0;

    axi_mem_reg_slice dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 36'h0_1234_5678;
        m_axi_arready = 1'b0;
        tick; tick; tick;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b expected 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid});
        end
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_readies: got %b expected 00000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready});
        end
        aresetn = 1'b1;
        tick;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready} !== 5'b11111) begin
            errors++;
            $display("FAIL readies_after_release: got %b expected 11111",
                     {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready});
        end
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL arvalid_before_accept: got %b expected 0", m_axi_arvalid);
        end
        tick;   // first AR accepted on this edge
        s_axi_arvalid = 1'b0;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 36'h0_1234_5678) begin
            errors++;
            $display("FAIL first_ar_latency: got v=%b a=%h expected v=1 a=012345678",
                     m_axi_arvalid, m_axi_araddr);
        end
        m_axi_arready = 1'b1;
        tick;
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_drain: got %b expected 0", m_axi_arvalid);
        end
    endtask

    task automatic test_stream;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 36'h0_0000_2000;
        s_axi_awlen   = 8'd15;
        s_axi_awid    = 8'h11;
        tick;
        s_axi_awvalid = 1'b0;
        checks++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awlen !== 8'd15 || m_axi_awid !== 8'h11) begin
            errors++;
            $display("FAIL stream_aw: got v=%b len=%0d id=%h expected v=1 len=15 id=11",
                     m_axi_awvalid, m_axi_awlen, m_axi_awid);
        end
        for (int i = 0; i < 16; i++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = 64'(i);
            s_axi_wstrb  = 8'hFF;
            s_axi_wlast  = (i == 15);
            checks++;
            if (s_axi_wready !== 1'b1) begin
                errors++;
                $display("FAIL stream_wready beat %0d: got %b expected 1", i, s_axi_wready);
            end
            tick;
            checks++;
            if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== 64'(i) ||
                m_axi_wstrb !== 8'hFF || m_axi_wlast !== (i == 15)) begin
                errors++;
                $display("FAIL stream_w beat %0d: got v=%b d=%0h s=%h l=%b expected v=1 d=%0h s=ff l=%b",
                         i, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, i, (i == 15));
            end
        end
        s_axi_wvalid = 1'b0;
        tick;
        checks++;
        if (m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got wv=%b awv=%b expected 0 0", m_axi_wvalid, m_axi_awvalid);
        end
    endtask

    task automatic test_skid;
        logic [35:0] exp_q[$];
        logic [35:0] held;
        logic        inf, outf;
        int          sent, rcvd, extra;
        sent = 0; rcvd = 0; extra = 0; held = '0;
        for (int c = 0; c < 60; c++) begin
            if (sent < 10) begin
                s_axi_arvalid = 1'b1;
                s_axi_araddr  = 36'h1_0000_0000 + 36'(sent) * 36'd64;
                s_axi_arid    = 8'(sent);
            end else begin
                s_axi_arvalid = 1'b0;
            end
            m_axi_arready = !(c >= 4 && c <= 6);
            if (c == 4) held = m_axi_araddr;
            if (c == 5 || c == 6) begin
                checks++;
                if (s_axi_arready !== 1'b0 || m_axi_arvalid !== 1'b1 || m_axi_araddr !== held) begin
                    errors++;
                    $display("FAIL skid_stall c=%0d: got rdy=%b v=%b a=%h expected rdy=0 v=1 a=%h",
                             c, s_axi_arready, m_axi_arvalid, m_axi_araddr, held);
                end
            end
            if (c == 8) begin
                checks++;
                if (s_axi_arready !== 1'b1) begin
                    errors++;
                    $display("FAIL skid_recover: got %b expected 1", s_axi_arready);
                end
            end
            inf  = s_axi_arvalid & s_axi_arready;
            outf = m_axi_arvalid & m_axi_arready;
            if (inf && c >= 4 && c <= 6) extra++;
            if (outf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL skid_order: got %h expected nothing", m_axi_araddr);
                end else begin
                    if (m_axi_araddr !== exp_q[0]) begin
                        errors++;
                        $display("FAIL skid_order: got %h expected %h", m_axi_araddr, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                rcvd++;
            end
            if (inf) begin
                exp_q.push_back(s_axi_araddr);
                sent++;
            end
            tick;
            if (sent == 10 && exp_q.size() == 0 && c > 8) break;
        end
        s_axi_arvalid = 1'b0;
        checks++;
        if (extra != 1) begin
            errors++;
            $display("FAIL skid_extra: got %0d expected 1", extra);
        end
        checks++;
        if (rcvd != 10) begin
            errors++;
            $display("FAIL skid_count: got %0d expected 10", rcvd);
        end
    endtask

    task automatic test_reverse_r;
        int   j, k;
        logic inf, outf;
        j = 0; k = 0;
        for (int c = 0; c < 200; c++) begin
            if (j < 8) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = 64'hA5A5_0000_0000_0000 | 64'(j);
                m_axi_rid    = 8'h5A;
                m_axi_rresp  = 2'b00;
                m_axi_rlast  = (j == 7);
            end else begin
                m_axi_rvalid = 1'b0;
            end
            s_axi_rready = 1'($urandom_range(0, 1));
            inf  = m_axi_rvalid & m_axi_rready;
            outf = s_axi_rvalid & s_axi_rready;
            if (outf) begin
                checks++;
                if (s_axi_rdata !== (64'hA5A5_0000_0000_0000 | 64'(k)) || s_axi_rid !== 8'h5A ||
                    s_axi_rresp !== 2'b00 || s_axi_rlast !== (k == 7)) begin
                    errors++;
                    $display("FAIL r_beat %0d: got d=%h id=%h resp=%b last=%b expected d=%h id=5a resp=00 last=%b",
                             k, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast,
                             64'hA5A5_0000_0000_0000 | 64'(k), (k == 7));
                end
                k++;
            end
            if (inf) j++;
            tick;
            if (k == 8) break;
        end
        m_axi_rvalid = 1'b0;
        s_axi_rready = 1'b1;
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL r_count: got %0d expected 8", k);
        end
        tick;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_no_extra: got %b expected 0", s_axi_rvalid);
        end
    endtask

    task automatic test_reverse_b;
        int   j, k;
        logic inf, outf;
        j = 0; k = 0;
        for (int c = 0; c < 100; c++) begin
            if (j < 4) begin
                m_axi_bvalid = 1'b1;
                m_axi_bid    = 8'h30 + 8'(j);
                m_axi_bresp  = 2'b10;
            end else begin
                m_axi_bvalid = 1'b0;
            end
            s_axi_bready = 1'($urandom_range(0, 1));
            inf  = m_axi_bvalid & m_axi_bready;
            outf = s_axi_bvalid & s_axi_bready;
            if (outf) begin
                checks++;
                if (s_axi_bid !== 8'h30 + 8'(k) || s_axi_bresp !== 2'b10) begin
                    errors++;
                    $display("FAIL b_beat %0d: got id=%h resp=%b expected id=%h resp=10",
                             k, s_axi_bid, s_axi_bresp, 8'h30 + 8'(k));
                end
                k++;
            end
            if (inf) j++;
            tick;
            if (k == 4) break;
        end
        m_axi_bvalid = 1'b0;
        s_axi_bready = 1'b1;
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL b_count: got %0d expected 4", k);
        end
        tick;
    endtask

    task automatic test_addr_transparency;
        m_axi_awready = 1'b1;
        m_axi_arready = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 36'h8_0000_1000;
        s_axi_awcache = 4'hB;
        s_axi_awprot  = 3'b101;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 36'hF_FFFF_FFC0;
        s_axi_arqos   = 4'hC;
        tick;
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        checks++;
        if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 36'h8_0000_1000 ||
            m_axi_awcache !== 4'hB || m_axi_awprot !== 3'b101) begin
            errors++;
            $display("FAIL aw_transparent: got v=%b a=%h cache=%h prot=%b expected v=1 a=800001000 cache=b prot=101",
                     m_axi_awvalid, m_axi_awaddr, m_axi_awcache, m_axi_awprot);
        end
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 36'hF_FFFF_FFC0 || m_axi_arqos !== 4'hC) begin
            errors++;
            $display("FAIL ar_transparent: got v=%b a=%h qos=%h expected v=1 a=fffffffc0 qos=c",
                     m_axi_arvalid, m_axi_araddr, m_axi_arqos);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int stale;
        stale = 0;
        m_axi_awready = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 36'h2_0000_0000;
        tick;                       // EMPTY -> HALF
        s_axi_awaddr  = 36'h2_0000_0040;
        tick;                       // HALF -> FULL
        s_axi_awvalid = 1'b0;
        checks++;
        if (s_axi_awready !== 1'b0 || m_axi_awvalid !== 1'b1) begin
            errors++;
            $display("FAIL aw_full: got rdy=%b v=%b expected rdy=0 v=1", s_axi_awready, m_axi_awvalid);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_awvalid: got %b expected 0", m_axi_awvalid);
        end
        tick; tick;
        aresetn = 1'b1;
        m_axi_awready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (m_axi_awvalid === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_aw: got %0d valid cycles expected 0", stale);
        end
        checks++;
        if (s_axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL awready_after_reset: got %b expected 1", s_axi_awready);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
        s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        test_reset;
        test_stream;
        test_skid;
        test_reverse_r;
        test_reverse_b;
        test_addr_transparency;
        test_reset_mid;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_reg_slice.md
# axi_mem_reg_slice

Full AXI4 register slice placed directly upstream of the DDR address-remapping stage, on the memory port between the SoC master and the remapper. It cuts every combinational path through all five channels (AW, W, B, AR, R) with a 2-entry skid buffer per channel. Addresses and payloads are never modified. The slice adds one cycle of latency and keeps full 1-beat/cycle throughput.

## Interface
- ADDR_WIDTH, 36, AW/AR address width
- DATA_WIDTH, 64, W/R data width; WSTRB width = DATA_WIDTH/8
- ID_WIDTH, 8, AWID/BID/ARID/RID width
- aclk  input  1  sole clock; all state updates on its rising edge
- aresetn  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to aclk in the SoC
- s_axi_aw{addr,id,len,size,burst,lock,cache,prot,qos}, s_axi_awvalid  input  AXI4 widths  write address from master
- s_axi_awready  output  1  slice can accept AW
- s_axi_w{data,strb,last}, s_axi_wvalid  input  DATA_WIDTH, DATA_WIDTH/8, 1, 1  write data
- s_axi_wready  output  1
- s_axi_b{id,resp}, s_axi_bvalid  output  ID_WIDTH, 2, 1  write response to master
- s_axi_bready  input  1
- s_axi_ar{addr,id,len,size,burst,lock,cache,prot,qos}, s_axi_arvalid  input  AXI4 widths  read address
- s_axi_arready  output  1
- s_axi_r{data,id,resp,last}, s_axi_rvalid  output  DATA_WIDTH, ID_WIDTH, 2, 1  read data to master
- s_axi_rready  input  1
- m_axi_*  mirror of s_axi_* with directions reversed, toward the remapper

## Operation
- Five independent instances of one skid-buffer channel. Forward channels: AW, W, AR (s->m). Reverse channels: B, R (m->s).
- Per channel: output register OUT (payload + valid), skid register SK (payload + valid), registered ready RDY_q = !SK.valid.
- States per channel:
  - EMPTY: OUT.v=0, SK.v=0
  - HALF: OUT.v=1, SK.v=0
  - FULL: OUT.v=1, SK.v=1
- Input handshake: in_fire = in_valid & RDY_q. Output handshake: out_fire = OUT.v & out_ready.
- Transitions:
  - EMPTY: in_fire -> HALF, load OUT.
  - HALF:
    - in_fire & out_fire -> HALF, load OUT with new beat.
    - in_fire & !out_fire -> FULL, load SK.
    - !in_fire & out_fire -> EMPTY.
  - FULL (RDY_q=0, so no in_fire): out_fire -> HALF, move SK into OUT; otherwise hold.
- Payloads are stored and forwarded bit-exact, with no width change and no reordering. Per-channel ordering is strict FIFO. No cross-channel ordering is imposed; AXI rules already cover that.
- OUT payload must not change while OUT.v=1 and out_ready=0 (AXI stability). SK is written only on HALF & in_fire & !out_fire.
- Ready is a pure flop. There is no combinational path from any input to any output.

## Timing
- Reset (aresetn=0, asynchronous): every valid output (m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid) = 0. All SK.v = 0. Every ready output (s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready) = 0.
- Ready outputs go to 1 on the first aclk edge after aresetn deasserts.
- Payload registers are not reset; their value is don't-care while valid=0.
- Latency: a beat accepted at edge N appears on the output side with valid=1 after edge N (visible in cycle N+1).
- Throughput: with the sink always ready, one beat per cycle sustained indefinitely with no bubbles.
- Back-pressure: the sink drops ready for K cycles. The slice absorbs exactly one extra beat (FULL), then deasserts its input ready one cycle later.
- Recovery from FULL: input ready re-asserts on the edge after the first out_fire.
- Reset mid-transfer: all buffered beats are discarded and the slice returns to EMPTY asynchronously. Upstream and downstream must be reset together.

## Test plan
- Reset: hold aresetn=0 with s_axi_arvalid=1 -> all valids 0 and all readies 0. Readies become 1 one cycle after release. m_axi_arvalid rises one cycle after the first accepted AR.
- Streaming: 16-beat write burst (awlen=15, wdata=0..15, wlast on beat 15) with the sink always ready -> m_axi_w* carries 0..15 contiguously, wlast on beat 15, first beat one cycle after acceptance.
- Skid: AR stream with m_axi_arready dropped for 3 cycles mid-stream -> exactly one extra AR accepted, then s_axi_arready=0. No beat lost or duplicated; m_axi_araddr stays stable while stalled.
- Reverse channels: m_axi_rvalid burst (rid=0x5A, 8 beats) with random s_axi_rready (50%) -> s_axi_r* delivers all 8 beats in order with rid=0x5A and rlast only on beat 8. Same check for B with bresp=2'b10 passed through unchanged.
- Address transparency: awaddr=0x8_0000_1000 and araddr=0xF_FFFF_FFC0 -> identical values on m_axi_awaddr/m_axi_araddr.
- Reset mid-operation: aresetn pulsed low while AW is FULL -> m_axi_awvalid=0 immediately. No stale AW is emitted after release.
